// File: rtl/shifter_pkg.sv
// Shared constants for the logical/rotating barrel shifter.
// Holds the default data width and the direction encoding used on left_or_right.
package shifter_pkg;

   localparam int   WIDTH_DEFAULT = 16;

   // Direction encoding for the left_or_right input
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

endpackage : shifter_pkg

// File: rtl/shifter_stage.sv
// One logarithmic stage of the barrel shifter.
// Shifts din by the fixed amount AMT when en=1, otherwise passes it through.
// Vacated bits are zero-filled, or filled with the bits shifted out at the
// other end when rot=1.
module shifter_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int AMT   = 1
) (
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   input  logic             dir,
   input  logic             rot,
   output logic [WIDTH-1:0] dout
);

   logic [AMT-1:0]   fill_left;
   logic [AMT-1:0]   fill_right;
   logic [WIDTH-1:0] shifted_left;
   logic [WIDTH-1:0] shifted_right;

   // Pick the fill bits, then form both shifted words and select by direction/enable
   always_comb begin
      fill_left     = rot ? din[WIDTH-1 -: AMT] : {AMT{1'b0}};
      fill_right    = rot ? din[AMT-1:0]        : {AMT{1'b0}};
      shifted_left  = {din[WIDTH-AMT-1:0], fill_left};
      shifted_right = {fill_right, din[WIDTH-1:AMT]};
      if (!en)
         dout = din;
      else if (dir == DIR_LEFT)
         dout = shifted_left;
      else
         dout = shifted_right;
   end

endmodule : shifter_stage

// File: rtl/shifter16_lr.sv
// Registered logical barrel shifter, left or right by 0..WIDTH-1 bits.
// One-cycle latency, one operand per clock. Define SHIFTER_ROTATE_EN to make
// rot=1 select a rotate instead of a logical shift; without it rot is ignored.
module shifter16_lr
   import shifter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   localparam int SHW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] x,
   input  logic [SHW-1:0]   shift,
   input  logic             left_or_right,
   input  logic             rot,
   output logic             out_valid,
   output logic [WIDTH-1:0] result
);

   logic             rot_eff;
   logic [WIDTH-1:0] stage_data [0:SHW];
   logic [WIDTH-1:0] result_reg;
   logic             out_valid_reg;

`ifdef SHIFTER_ROTATE_EN
   assign rot_eff = rot;
`else
   // Port kept for a stable interface; the rotate path folds away
   logic rot_unused;
   assign rot_unused = rot;
   assign rot_eff    = 1'b0;
`endif

   assign stage_data[0] = x;

   // Stage k shifts by 2^k when shift[k] is set
   generate
      for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
         shifter_stage #(
            .WIDTH (WIDTH),
            .AMT   (1 << gi)
         ) u_stage (
            .din  (stage_data[gi]),
            .en   (shift[gi]),
            .dir  (left_or_right),
            .rot  (rot_eff),
            .dout (stage_data[gi+1])
         );
      end
   endgenerate

   // Output register: valid follows in_valid, result loads only on valid operands
   always_ff @(posedge clk) begin
      if (rst) begin
         result_reg    <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= in_valid;
         if (in_valid)
            result_reg <= stage_data[SHW];
      end
   end

   assign result    = result_reg;
   assign out_valid = out_valid_reg;

endmodule : shifter16_lr

// File: tb/tb_shifter16_lr.sv
// Directed testbench for shifter16_lr: fixed vectors, shift sweeps, reset and hold.
module tb_shifter16_lr;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] x;
   logic [3:0]  shift;
   logic        left_or_right;
   logic        rot;
   logic        out_valid;
   logic [15:0] result;

   int n_checks = 0;
   int n_pass   = 0;

   shifter16_lr dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .x             (x),
      .shift         (shift),
      .left_or_right (left_or_right),
      .rot           (rot),
      .out_valid     (out_valid),
      .result        (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %s got=%h", tag, got);
      end else begin
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drive one operand, let it pass the clock edge, sample just after
   task automatic step(input logic [15:0] xv, input int s, input logic dir,
                       input logic rv, input logic vld);
      x             = xv;
      shift         = 4'(s);
      left_or_right = dir;
      rot           = rv;
      in_valid      = vld;
      @(posedge clk);
      #1;
   endtask

   task automatic shift_check(input string tag, input logic [15:0] xv, input int s,
                              input logic dir, input logic rv, input logic [15:0] exp);
      step(xv, s, dir, rv, 1'b1);
      check({tag, " valid"}, {15'b0, out_valid}, 16'h0001);
      check(tag, result, exp);
   endtask

   initial begin
      logic [15:0] xs [2];
      logic [15:0] e;
      xs[0] = 16'hFFFF;
      xs[1] = 16'h00FF;

      rst = 1'b1; in_valid = 1'b0; x = '0; shift = '0; left_or_right = 1'b0; rot = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset result", result, 16'h0000);
      check("reset valid", {15'b0, out_valid}, 16'h0000);
      rst = 1'b0;

      shift_check("ffff r1",  16'hFFFF, 1,  1'b0, 1'b0, 16'h7FFF);
      shift_check("ffff r15", 16'hFFFF, 15, 1'b0, 1'b0, 16'h0001);
      shift_check("ffff l4",  16'hFFFF, 4,  1'b1, 1'b0, 16'hFFF0);
      shift_check("ffff l15", 16'hFFFF, 15, 1'b1, 1'b0, 16'h8000);
      shift_check("00ff l0",  16'h00FF, 0,  1'b1, 1'b0, 16'h00FF);
      shift_check("00ff r0",  16'h00FF, 0,  1'b0, 1'b0, 16'h00FF);
      shift_check("00ff r8",  16'h00FF, 8,  1'b0, 1'b0, 16'h0000);
      shift_check("8001 l1",  16'h8001, 1,  1'b1, 1'b0, 16'h0002);
      shift_check("8001 r1",  16'h8001, 1,  1'b0, 1'b0, 16'h4000);

`ifdef SHIFTER_ROTATE_EN
      shift_check("rot r4",   16'h00FF, 4,  1'b0, 1'b1, 16'hF00F);
      shift_check("rot l4",   16'h00FF, 4,  1'b1, 1'b1, 16'h0FF0);
      shift_check("rot l15",  16'h8001, 15, 1'b1, 1'b1, 16'hC000);
      shift_check("rot r15",  16'h8001, 15, 1'b0, 1'b1, 16'h0003);
`else
      shift_check("rot-off r4",  16'h00FF, 4,  1'b0, 1'b1, 16'h000F);
      shift_check("rot-off l4",  16'h00FF, 4,  1'b1, 1'b1, 16'h0FF0);
      shift_check("rot-off l15", 16'h8001, 15, 1'b1, 1'b1, 16'h8000);
      shift_check("rot-off r15", 16'h8001, 15, 1'b0, 1'b1, 16'h0001);
`endif

      // Sweep every non-zero shift amount in both directions
      for (int k = 0; k < 2; k++) begin
         for (int s = 1; s < 16; s++) begin
            e = xs[k] << s;
            shift_check($sformatf("sweep %h l%0d", xs[k], s), xs[k], s, 1'b1, 1'b0, e);
            e = xs[k] >> s;
            shift_check($sformatf("sweep %h r%0d", xs[k], s), xs[k], s, 1'b0, 1'b0, e);
         end
      end

      // in_valid=0 holds the previous result and drops out_valid
      shift_check("load a5a5", 16'hA5A5, 0, 1'b0, 1'b0, 16'hA5A5);
      step(16'h1234, 2, 1'b1, 1'b0, 1'b0);
      check("hold result", result, 16'hA5A5);
      check("hold valid", {15'b0, out_valid}, 16'h0000);
      step(16'h1234, 2, 1'b1, 1'b0, 1'b0);
      check("hold result 2", result, 16'hA5A5);

      // Reset overrides an in-flight operand
      rst = 1'b1;
      step(16'hFFFF, 1, 1'b1, 1'b0, 1'b1);
      check("rst result", result, 16'h0000);
      check("rst valid", {15'b0, out_valid}, 16'h0000);
      rst = 1'b0;
      shift_check("after rst", 16'h0F0F, 4, 1'b1, 1'b0, 16'hF0F0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_shifter16_lr
